button_chord_encoder: RTL and testbench

//  Front end of the calculator keypad. Takes the 10 raw push-button lines and

---
 rtl/button_chord_encoder.sv | 145 ++++++++++++++
 tb/tb_button_chord_encoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/button_chord_encoder.sv
// rtl/button_chord_encoder.sv - keypad front end: sync, debounce, chord merge, one-shot code
module button_chord_encoder #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CHORD_WINDOW    = 25000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] key_raw,
    output logic [9:0] button,
    output logic       button_valid,
    output logic       key_error,
    output logic       chord_active
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_EMIT     = 2'd2,
        S_WAIT_REL = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(CHORD_WINDOW - 1);

    logic [9:0]       r_sync [SYNC_STAGES];
    logic [9:0]       r_db;
    logic [CNT_W-1:0] r_cnt [10];
    state_t           r_state;
    logic [9:0]       r_chord;
    logic [CNT_W-1:0] r_wcnt;
    logic [9:0]       r_button;
    logic             r_button_valid;
    logic             r_key_error;
    logic             r_chord_active;

    state_t           w_state_next;
    logic [9:0]       w_chord_next;
    logic [CNT_W-1:0] w_wcnt_next;
    logic [9:0]       w_s;
    logic             w_legal;

    // The chord set the calculator FSM understands: single digits and the operator chords.
    function automatic logic f_legal(input logic [9:0] c);
        logic onehot;
        onehot = (c != 10'h000) && ((c & (c - 10'h001)) == 10'h000);
        f_legal = onehot || (c == 10'h201) || (c == 10'h202) || (c == 10'h204) ||
                  (c == 10'h208) || (c == 10'h300) || (c == 10'h380);
    endfunction

    assign w_s     = r_sync[SYNC_STAGES-1];
    assign w_legal = f_legal(w_chord_next);

    // Multi-flop synchroniser for the asynchronous button lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 10'h000;
        end else begin
            r_sync[0] <= key_raw;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    // Per-line debounce: a line flips only after it has disagreed for DEBOUNCE_CYCLES in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db <= 10'h000;
            for (int i = 0; i < 10; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (w_s[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_db[i]  <= w_s[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Chord FSM state, accumulated chord and window counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_chord <= 10'h000;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_chord <= w_chord_next;
            r_wcnt  <= w_wcnt_next;
        end
    end

    // Next-state logic: keys only accumulate during COLLECT; release or window expiry ends it.
    always_comb begin
        w_state_next = r_state;
        w_chord_next = r_chord;
        w_wcnt_next  = r_wcnt;
        case (r_state)
            S_IDLE: begin
                if (r_db != 10'h000) begin
                    w_chord_next = r_db;
                    w_wcnt_next  = '0;
                    w_state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                w_chord_next = r_chord | r_db;
                w_wcnt_next  = r_wcnt + 1'b1;
                if ((r_db == 10'h000) || (r_wcnt == WIN_LAST)) w_state_next = S_EMIT;
            end
            S_EMIT: begin
                w_state_next = (r_db == 10'h000) ? S_IDLE : S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (r_db == 10'h000) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are flopped from the next state so they line up exactly with the EMIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_button       <= 10'h000;
            r_button_valid <= 1'b0;
            r_key_error    <= 1'b0;
            r_chord_active <= 1'b0;
        end else begin
            r_button       <= ((w_state_next == S_EMIT) && w_legal) ? w_chord_next : 10'h000;
            r_button_valid <= (w_state_next == S_EMIT) && w_legal;
            r_key_error    <= (w_state_next == S_EMIT) && !w_legal;
            r_chord_active <= (w_state_next != S_IDLE);
        end
    end

    assign button       = r_button;
    assign button_valid = r_button_valid;
    assign key_error    = r_key_error;
    assign chord_active = r_chord_active;

endmodule

// File: tb/tb_button_chord_encoder.sv
// tb/tb_button_chord_encoder.sv - directed self-checking bench for button_chord_encoder
module tb_button_chord_encoder;

    logic       clk;
    logic       rst;
    logic [9:0] key_raw;
    logic [9:0] button;
    logic       button_valid;
    logic       key_error;
    logic       chord_active;

    int checks;
    int errors;

    int         cyc;
    int         n_valid;
    int         n_err;
    int         n_active;
    int         n_bad;
    int         last_valid_cyc;
    logic [9:0] last_btn;

    int v0, e0, a0, t0;
    int wait_cnt;

    button_chord_encoder #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CHORD_WINDOW   (8),
        .CNT_W          (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_raw     (key_raw),
        .button      (button),
        .button_valid(button_valid),
        .key_error   (key_error),
        .chord_active(chord_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor, sampled on the falling edge.
    initial begin
        cyc = 0; n_valid = 0; n_err = 0; n_active = 0; n_bad = 0;
        last_valid_cyc = 0; last_btn = 10'h000;
    end
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (button_valid === 1'b1) begin
                n_valid = n_valid + 1;
                last_btn = button;
                last_valid_cyc = cyc;
            end
            if (key_error === 1'b1) n_err = n_err + 1;
            if (chord_active === 1'b1) n_active = n_active + 1;
            if ((button_valid === 1'b1) && (key_error === 1'b1)) n_bad = n_bad + 1;
            if ((button_valid !== 1'b1) && (button !== 10'h000)) n_bad = n_bad + 1;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        v0 = n_valid;
        e0 = n_err;
        a0 = n_active;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        key_raw = 10'h3FF;

        // 1: reset with all keys held, then one key_error for the illegal 3FF chord
        tick(3);
        check("rst_button", 32'(button), 32'h000);
        check("rst_valid", 32'(button_valid), 32'h0);
        check("rst_error", 32'(key_error), 32'h0);
        check("rst_active", 32'(chord_active), 32'h0);
        snap();
        rst = 1'b0;
        tick(40);
        check("t1_err_count", 32'(n_err - e0), 32'd1);
        check("t1_valid_count", 32'(n_valid - v0), 32'd0);
        key_raw = 10'h000;
        tick(20);
        check("t1_idle_active", 32'(chord_active), 32'h0);

        // 2: single key 5 held 30 cycles
        snap();
        t0 = cyc;
        key_raw = 10'h020;
        tick(30);
        key_raw = 10'h000;
        tick(20);
        check("t2_valid_count", 32'(n_valid - v0), 32'd1);
        check("t2_button", 32'(last_btn), 32'h020);
        check("t2_err_count", 32'(n_err - e0), 32'd0);
        check("t2_latency_min", 32'(last_valid_cyc - t0 >= 6), 32'h1);
        check("t2_latency_max", 32'(last_valid_cyc - t0 <= 17), 32'h1);
        check("t2_idle_active", 32'(chord_active), 32'h0);

        // 3: 9 then 0 two cycles later -> single 201 chord
        snap();
        key_raw = 10'h200;
        tick(2);
        key_raw = 10'h201;
        tick(20);
        key_raw = 10'h000;
        tick(20);
        check("t3_valid_count", 32'(n_valid - v0), 32'd1);
        check("t3_button", 32'(last_btn), 32'h201);
        check("t3_err_count", 32'(n_err - e0), 32'd0);

        // 4: bit 3 bouncing every 2 cycles never gets through the debouncer
        snap();
        for (int i = 0; i < 6; i++) begin
            key_raw = (i % 2 == 0) ? 10'h008 : 10'h000;
            tick(2);
        end
        key_raw = 10'h000;
        tick(12);
        check("t4_valid_count", 32'(n_valid - v0), 32'd0);
        check("t4_err_count", 32'(n_err - e0), 32'd0);
        check("t4_active_count", 32'(n_active - a0), 32'd0);

        // 5: 1+2 is not a legal chord
        snap();
        key_raw = 10'h006;
        tick(15);
        key_raw = 10'h000;
        tick(20);
        check("t5_err_count", 32'(n_err - e0), 32'd1);
        check("t5_valid_count", 32'(n_valid - v0), 32'd0);

        // 6: reset pulsed mid-chord, then 9+8 held -> only the 300 strobe
        snap();
        key_raw = 10'h200;
        wait_cnt = 0;
        while ((chord_active !== 1'b1) && (wait_cnt < 30)) begin
            tick(1);
            wait_cnt = wait_cnt + 1;
        end
        check("t6_collect_reached", 32'(chord_active), 32'h1);
        rst = 1'b1;
        key_raw = 10'h300;
        tick(1);
        check("t6_rst_active", 32'(chord_active), 32'h0);
        check("t6_rst_button", 32'(button), 32'h000);
        rst = 1'b0;
        tick(30);
        key_raw = 10'h000;
        tick(20);
        check("t6_valid_count", 32'(n_valid - v0), 32'd1);
        check("t6_button", 32'(last_btn), 32'h300);
        check("t6_err_count", 32'(n_err - e0), 32'd0);

        // Output invariants over the whole run
        check("no_overlap_or_stray_button", 32'(n_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
